// File: rtl/gate_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gate_arb_pkg
// Brief    : Shared state encoding, default sizes and operand slice helper
//            for the gate unit arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package gate_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int C_DEF_NUM_REQ = 4;
  localparam int C_DEF_WIDTH   = 8;

  // Base bit of requester idx's operand slice within a packed operand bus.
  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/and_or_unit.sv
`default_nettype none
// ============================================================================
// Module   : and_or_unit
// Brief    : Shared combinational datapath: t = a & b, o1 = t & c, o2 = t | c.
// Revision : 1.0 - initial release
// ============================================================================
module and_or_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2
);

  logic [WIDTH-1:0] w_t;

  assign w_t = a & b;
  assign o1  = w_t & c;
  assign o2  = w_t | c;

endmodule
`default_nettype wire

// File: rtl/gate_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gate_unit_arbiter
// Brief    : Round-robin arbiter sharing one AND/OR datapath among NUM_REQ
//            requesters, returning tagged results over a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module gate_unit_arbiter
  import gate_arb_pkg::*;
#(
  parameter  int NUM_REQ = C_DEF_NUM_REQ,
  parameter  int WIDTH   = C_DEF_WIDTH,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_in_1,
  input  logic [NUM_REQ*WIDTH-1:0] req_in_2,
  input  logic [NUM_REQ*WIDTH-1:0] req_in_3,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ID_W-1:0]          res_id,
  output logic [WIDTH-1:0]         res_out_1,
  output logic [WIDTH-1:0]         res_out_2,
  output logic                     busy
);

  arb_state_t         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    r_res_id;
  logic               r_res_valid;
  logic [WIDTH-1:0]   r_op_1, r_op_2, r_op_3;
  logic [WIDTH-1:0]   r_res_out_1, r_res_out_2;

  logic               w_found;
  logic [ID_W-1:0]    w_winner;
  logic [ID_W-1:0]    w_next_ptr;
  logic [WIDTH-1:0]   w_sel_1, w_sel_2, w_sel_3;
  logic [WIDTH-1:0]   w_o1, w_o2;

  // First active request at or after the pointer, wrapping past NUM_REQ-1.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_found  = 1'b1;
        w_winner = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    w_sel_1 = '0;
    w_sel_2 = '0;
    w_sel_3 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == ID_W'(i)) begin
        w_sel_1 = req_in_1[slice_lsb(i, WIDTH) +: WIDTH];
        w_sel_2 = req_in_2[slice_lsb(i, WIDTH) +: WIDTH];
        w_sel_3 = req_in_3[slice_lsb(i, WIDTH) +: WIDTH];
      end
    end
  end

  assign w_next_ptr = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;

  and_or_unit #(
    .WIDTH (WIDTH)
  ) u_and_or_unit (
    .a  (r_op_1),
    .b  (r_op_2),
    .c  (r_op_3),
    .o1 (w_o1),
    .o2 (w_o2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_ptr       <= '0;
      r_id        <= '0;
      r_res_id    <= '0;
      r_res_valid <= 1'b0;
      r_op_1      <= '0;
      r_op_2      <= '0;
      r_op_3      <= '0;
      r_res_out_1 <= '0;
      r_res_out_2 <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            r_gnt   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
            r_op_1  <= w_sel_1;
            r_op_2  <= w_sel_2;
            r_op_3  <= w_sel_3;
            r_id    <= w_winner;
            r_ptr   <= w_next_ptr;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_gnt       <= '0;
          r_res_out_1 <= w_o1;
          r_res_out_2 <= w_o2;
          r_res_id    <= r_id;
          r_res_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_gnt       <= '0;
          r_res_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res_out_1 = r_res_out_1;
  assign res_out_2 = r_res_out_2;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gate_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_unit_arbiter
// Brief    : Directed self-checking bench for gate_unit_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_unit_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ*WIDTH-1:0] req_in_1 = '0;
  logic [NUM_REQ*WIDTH-1:0] req_in_2 = '0;
  logic [NUM_REQ*WIDTH-1:0] req_in_3 = '0;
  logic [NUM_REQ-1:0]       gnt;
  logic                     res_valid;
  logic                     res_ready = 1'b0;
  logic [ID_W-1:0]          res_id;
  logic [WIDTH-1:0]         res_out_1;
  logic [WIDTH-1:0]         res_out_2;
  logic                     busy;

  int checks = 0;
  int errors = 0;

  gate_unit_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_in_1  (req_in_1),
    .req_in_2  (req_in_2),
    .req_in_3  (req_in_3),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_out_1 (res_out_1),
    .res_out_2 (res_out_2),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    req = '0;
    res_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    repeat (3) tick();
    checks++;
    if ({gnt, res_valid, res_id, res_out_1, res_out_2, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b v=%b id=%0d o1=%h o2=%h busy=%b expected all zero",
               gnt, res_valid, res_id, res_out_1, res_out_2, busy);
    end
    rst = 1'b0;
    req = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL reset_pre_grant: got %b expected 0001", gnt);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got gnt=%b busy=%b expected gnt=0000 busy=0", gnt, busy);
    end
    req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    res_ready = 1'b1;
    req_in_1[2*WIDTH +: WIDTH] = 8'hF0;
    req_in_2[2*WIDTH +: WIDTH] = 8'hCC;
    req_in_3[2*WIDTH +: WIDTH] = 8'hAA;
    req = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100 || busy !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: got gnt=%b busy=%b v=%b expected 0100 1 0", gnt, busy, res_valid);
    end
    req = '0;
    tick();
    checks++;
    if (gnt !== 4'b0000 || res_valid !== 1'b1 || res_id !== 2'd2 ||
        res_out_1 !== 8'h80 || res_out_2 !== 8'hEA) begin
      errors++;
      $display("FAIL single_result: got gnt=%b v=%b id=%0d o1=%h o2=%h expected 0000 1 2 80 EA",
               gnt, res_valid, res_id, res_out_1, res_out_2);
    end
    tick();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_handshake: got v=%b busy=%b expected 0 0", res_valid, busy);
    end
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_no_regrant: got gnt=%b busy=%b expected 0000 0", gnt, busy);
    end
  endtask

  task automatic wait_grant(input logic [NUM_REQ-1:0] exp, input int n);
    logic got;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (gnt !== 4'b0000) got = 1'b1;
    end
    checks++;
    if (!got || gnt !== exp) begin
      errors++;
      $display("FAIL rr_grant%0d: got %b (seen=%b) expected %b", n, gnt, got, exp);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    res_ready = 1'b1;
    req = 4'b1111;
    wait_grant(4'b0001, 0);
    wait_grant(4'b0010, 1);
    wait_grant(4'b0100, 2);
    wait_grant(4'b1000, 3);
    req = 4'b1001;
    wait_grant(4'b0001, 4);
    wait_grant(4'b1000, 5);
    wait_grant(4'b0001, 6);
    wait_grant(4'b1000, 7);
    drain();
  endtask

  task automatic test_back_to_back();
    res_ready = 1'b1;
    req = 4'b0001;
    wait_grant(4'b0001, 8);
    for (int c = 1; c <= 2; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0000) begin
        errors++;
        $display("FAIL b2b_gap%0d: got %b expected 0000", c, gnt);
      end
    end
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL b2b_regrant: got %b expected 0001", gnt);
    end
    drain();
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    req_in_1[3*WIDTH +: WIDTH] = 8'hFF;
    req_in_2[3*WIDTH +: WIDTH] = 8'h0F;
    req_in_3[3*WIDTH +: WIDTH] = 8'h30;
    req = 4'b1000;
    wait_grant(4'b1000, 9);
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_id !== 2'd3 || res_out_1 !== 8'h00 ||
          res_out_2 !== 8'h3F || busy !== 1'b1 || gnt !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b id=%0d o1=%h o2=%h busy=%b gnt=%b expected 1 3 00 3F 1 0000",
                 c, res_valid, res_id, res_out_1, res_out_2, busy, gnt);
      end
    end
    res_ready = 1'b1;
    tick();
    req = '0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got v=%b busy=%b expected 0 0", res_valid, busy);
    end
    drain();
  endtask

  task automatic test_isolation();
    res_ready = 1'b1;
    req_in_1[1*WIDTH +: WIDTH] = 8'h3C;
    req_in_2[1*WIDTH +: WIDTH] = 8'hFF;
    req_in_3[1*WIDTH +: WIDTH] = 8'h0F;
    req = 4'b0010;
    wait_grant(4'b0010, 10);
    req_in_1[1*WIDTH +: WIDTH] = 8'h00;
    req_in_2[1*WIDTH +: WIDTH] = 8'h00;
    req_in_3[1*WIDTH +: WIDTH] = 8'hFF;
    req = '0;
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd1 || res_out_1 !== 8'h0C || res_out_2 !== 8'h3F) begin
      errors++;
      $display("FAIL isolation: got v=%b id=%0d o1=%h o2=%h expected 1 1 0C 3F",
               res_valid, res_id, res_out_1, res_out_2);
    end
    drain();
  endtask

  task automatic test_reset_in_resp();
    res_ready = 1'b0;
    req = 4'b0100;
    wait_grant(4'b0100, 11);
    req = '0;
    tick();
    checks++;
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL resp_before_reset: got v=%b expected 1", res_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || res_out_1 !== 8'h00 || res_id !== 2'd0) begin
      errors++;
      $display("FAIL resp_async_reset: got v=%b busy=%b o1=%h id=%0d expected 0 0 00 0",
               res_valid, busy, res_out_1, res_id);
    end
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;
    req = 4'b1010;
    wait_grant(4'b0010, 12);
    req = '0;
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd1) begin
      errors++;
      $display("FAIL post_reset_id: got v=%b id=%0d expected 1 1", res_valid, res_id);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_backpressure();
    test_isolation();
    test_reset_in_resp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
